difftest_axis_pkt_fifo: RTL



---
 rtl/difftest_axis_pkg.sv | 16 +
 rtl/difftest_axis_ram.sv | 26 ++
 rtl/difftest_axis_pkt_fifo.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/difftest_axis_pkg.sv
// Shared types and constants for the difftest host-stream packet buffer.
package difftest_axis_pkg;

    localparam int unsigned DIFFTEST_AXIS_DATA_W = 512;

    typedef struct packed {
        logic                            last;
        logic [DIFFTEST_AXIS_DATA_W-1:0] data;
    } difftest_axis_entry_t;

    typedef enum logic {
        PKT = 1'b0,
        CUT = 1'b1
    } difftest_axis_rel_e;

endpackage

// File: rtl/difftest_axis_ram.sv
// DEPTH x WIDTH storage array: one synchronous write port, one asynchronous read port.
module difftest_axis_ram #(
    parameter int unsigned WIDTH  = 513,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately never reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/difftest_axis_pkt_fifo.sv
// Store-and-forward packet buffer with cut-through fallback for oversize packets.
// Optional statistics counters are enabled with DIFFTEST_PKT_STATS_EN.
module difftest_axis_pkt_fifo
    import difftest_axis_pkg::*;
#(
    parameter int unsigned DATA_W = DIFFTEST_AXIS_DATA_W,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              s_axis_valid,
    output logic              s_axis_ready,
    input  logic [DATA_W-1:0] s_axis_data,
    input  logic              s_axis_last,
    output logic              m_axis_valid,
    input  logic              m_axis_ready,
    output logic [DATA_W-1:0] m_axis_data,
    output logic              m_axis_last,
    output logic [CNT_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  pkt_count,
`ifdef DIFFTEST_PKT_STATS_EN
    output logic [31:0]       stat_beats_in,
    output logic [31:0]       stat_pkts_out,
    output logic [31:0]       stat_stall_cycles,
`endif
    output logic              overflow_release
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = DATA_W + 1;

    difftest_axis_rel_e state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic [CNT_W-1:0]   pkt_q, pkt_d;
    logic               ovf_q, ovf_d;
    logic               cut_open_q, cut_open_d;

    logic               push_c;
    logic               pop_c;
    logic               pkt_inc_c;
    logic               pkt_dec_c;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    difftest_axis_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .ADDR_W(PTR_W)
    ) u_ram (
        .clock  (clock),
        .wr_en  (push_c),
        .wr_addr(wr_ptr_q),
        .wr_data(wr_entry),
        .rd_addr(rd_ptr_q),
        .rd_data(rd_entry)
    );

    assign wr_entry     = {s_axis_last, s_axis_data};
    assign m_axis_data  = rd_entry[DATA_W-1:0];
    assign m_axis_last  = rd_entry[DATA_W];

    assign s_axis_ready = (occ_q != CNT_W'(DEPTH));
    assign m_axis_valid = (state_q == PKT) ? (pkt_q != '0) : (occ_q != '0);
    assign push_c       = s_axis_valid && s_axis_ready;
    assign pop_c        = m_axis_valid && m_axis_ready;

    // The oversize packet's last beat is never counted, so it must never be decremented.
    assign pkt_inc_c    = push_c && s_axis_last && !cut_open_q;
    assign pkt_dec_c    = pop_c && m_axis_last && (state_q == PKT);

    assign occupancy        = occ_q;
    assign pkt_count        = pkt_q;
    assign overflow_release = ovf_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= PKT;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            pkt_q      <= '0;
            ovf_q      <= 1'b0;
            cut_open_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            pkt_q      <= pkt_d;
            ovf_q      <= ovf_d;
            cut_open_q <= cut_open_d;
        end
    end

    // Next-state: release FSM, pointers and counters.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        pkt_d      = pkt_q;
        ovf_d      = ovf_q;
        cut_open_d = cut_open_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (s_axis_last) begin
                cut_open_d = 1'b0;
            end
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_c, pop_c})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase

        case ({pkt_inc_c, pkt_dec_c})
            2'b10:   pkt_d = pkt_q + CNT_W'(1);
            2'b01:   pkt_d = pkt_q - CNT_W'(1);
            default: pkt_d = pkt_q;
        endcase

        case (state_q)
            PKT: begin
                if ((occ_q == CNT_W'(DEPTH)) && (pkt_q == '0)) begin
                    state_d    = CUT;
                    ovf_d      = 1'b1;
                    cut_open_d = 1'b1;
                end
            end
            CUT: begin
                if (pop_c && m_axis_last) begin
                    state_d = PKT;
                end
            end
            default: state_d = PKT;
        endcase
    end

`ifdef DIFFTEST_PKT_STATS_EN
    logic [31:0] beats_in_q;
    logic [31:0] pkts_out_q;
    logic [31:0] stall_q;

    // Free-running wrapping statistics.
    always_ff @(posedge clock) begin
        if (reset) begin
            beats_in_q <= '0;
            pkts_out_q <= '0;
            stall_q    <= '0;
        end else begin
            if (push_c) begin
                beats_in_q <= beats_in_q + 32'(1);
            end
            if (pop_c && m_axis_last) begin
                pkts_out_q <= pkts_out_q + 32'(1);
            end
            if (s_axis_valid && !s_axis_ready) begin
                stall_q <= stall_q + 32'(1);
            end
        end
    end

    assign stat_beats_in     = beats_in_q;
    assign stat_pkts_out     = pkts_out_q;
    assign stat_stall_cycles = stall_q;
`endif

endmodule
